// File: rtl/prf_free_list_pkg.sv
// Shared CPU sizing constants for the rename-stage free list.
// FL_DEPTH and FL_PTR_W are exported so ROB/ID credit counters can be sized
// from the same source as the free list itself.
package prf_free_list_pkg;

  localparam int PRF_DEPTH = 64;
  localparam int ARF_DEPTH = 32;
  localparam int PRF_IDX   = $clog2(PRF_DEPTH);
  localparam int ARF_IDX   = $clog2(ARF_DEPTH);

  // Free list holds every physical register not pinned by the architectural map.
  localparam int FL_DEPTH  = PRF_DEPTH - ARF_DEPTH;
  localparam int FL_IDX_W  = $clog2(FL_DEPTH);
  // Extra MSB is the wrap bit that separates full from empty.
  localparam int FL_PTR_W  = FL_IDX_W + 1;
  localparam int FL_CNT_W  = $clog2(FL_DEPTH + 1);

  typedef logic [PRF_IDX-1:0]  prf_idx_t;
  typedef logic [ARF_IDX-1:0]  arf_idx_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;
  typedef logic [FL_CNT_W-1:0] fl_cnt_t;

endpackage

// File: rtl/prf_free_list_if.sv
// Rename/commit-side bundle of the physical register free list.
// master: rename + ROB driving requests; slave: the free list.
interface prf_free_list_if
  import prf_free_list_pkg::*;
();

  logic     alloc_valid;
  logic     alloc_ready;
  prf_idx_t alloc_idx;
  logic     commit_valid;
  prf_idx_t commit_old_phy;
  logic     flush;
  fl_cnt_t  free_count;
  logic     fl_err;

  modport master (
    output alloc_valid,
    output commit_valid,
    output commit_old_phy,
    output flush,
    input  alloc_ready,
    input  alloc_idx,
    input  free_count,
    input  fl_err
  );

  modport slave (
    input  alloc_valid,
    input  commit_valid,
    input  commit_old_phy,
    input  flush,
    output alloc_ready,
    output alloc_idx,
    output free_count,
    output fl_err
  );

endinterface

// File: rtl/prf_free_list.sv
// Physical register free list: circular FIFO of free PRF indices.
// Rename pops from head, commit pushes the superseded mapping at tail, and
// arch_head tracks the retired position so a flush rewinds head in one cycle.
// Optional integrity checking is enabled with the FREE_LIST_CHECK_EN macro.
module prf_free_list
  import prf_free_list_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  prf_free_list_if.slave fl
);

  // Advance a pointer by one slot, toggling the wrap bit at the last slot.
  function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
    fl_ptr_t r;
    if (p[FL_IDX_W-1:0] == FL_IDX_W'(FL_DEPTH - 1)) begin
      r = {~p[FL_PTR_W-1], {FL_IDX_W{1'b0}}};
    end else begin
      r = p + FL_PTR_W'(1);
    end
    return r;
  endfunction

  // Number of slots from lo up to (not including) hi, wrap-bit aware.
  function automatic fl_cnt_t ptr_dist(input fl_ptr_t hi, input fl_ptr_t lo);
    int d;
    d = int'(hi[FL_IDX_W-1:0]) - int'(lo[FL_IDX_W-1:0]);
    if (hi[FL_PTR_W-1] != lo[FL_PTR_W-1]) begin
      d = d + FL_DEPTH;
    end else begin
      d = d + 0;
    end
    return FL_CNT_W'(d);
  endfunction

  prf_idx_t mem_q [FL_DEPTH];
  fl_ptr_t  head_q, head_d;
  fl_ptr_t  tail_q, tail_d;
  fl_ptr_t  arch_head_q, arch_head_d;
  fl_cnt_t  free_count_q, free_count_d;
  logic     empty_s, full_s, pop_s, push_s;

  // Handshake qualification and next-state pointer arithmetic.
  always_comb begin
    empty_s = (head_q == tail_q);
    full_s  = (head_q[FL_IDX_W-1:0] == tail_q[FL_IDX_W-1:0]) &&
              (head_q[FL_PTR_W-1] != tail_q[FL_PTR_W-1]);
    // A flush discards the rename in the same cycle.
    pop_s   = fl.alloc_valid && !empty_s && !fl.flush;
    push_s  = fl.commit_valid && !full_s;

    if (push_s) begin
      tail_d      = ptr_inc(tail_q);
      arch_head_d = ptr_inc(arch_head_q);
    end else begin
      tail_d      = tail_q;
      arch_head_d = arch_head_q;
    end

    // Recovery rewinds to the retired head including this cycle's commit.
    if (fl.flush) begin
      head_d = arch_head_d;
    end else if (pop_s) begin
      head_d = ptr_inc(head_q);
    end else begin
      head_d = head_q;
    end

    free_count_d = ptr_dist(tail_d, head_d);
  end

  // Pointer and occupancy registers; reset image is a full list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      arch_head_q  <= '0;
      tail_q       <= {1'b1, {FL_IDX_W{1'b0}}};
      free_count_q <= FL_CNT_W'(FL_DEPTH);
    end else begin
      head_q       <= head_d;
      arch_head_q  <= arch_head_d;
      tail_q       <= tail_d;
      free_count_q <= free_count_d;
    end
  end

  // Index storage: reset to ARF_DEPTH+i, commit writes the freed index at tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem_q[i] <= PRF_IDX'(ARF_DEPTH + i);
      end
    end else begin
      if (push_s) begin
        mem_q[tail_q[FL_IDX_W-1:0]] <= fl.commit_old_phy;
      end
    end
  end

  assign fl.alloc_ready = !empty_s;
  assign fl.alloc_idx   = mem_q[head_q[FL_IDX_W-1:0]];
  assign fl.free_count  = free_count_q;

`ifdef FREE_LIST_CHECK_EN
  logic [PRF_DEPTH-1:0] in_list_q, in_list_d;
  logic                 err_s;
  logic                 fl_err_q;
  fl_cnt_t              inflight_s;
  logic [FL_IDX_W-1:0]  rs_slot_s;

  // Membership shadow: pop clears, flush re-marks in-flight entries, push sets.
  always_comb begin
    in_list_d  = in_list_q;
    err_s      = 1'b0;
    inflight_s = ptr_dist(head_q, arch_head_d);
    rs_slot_s  = '0;

    if (pop_s) begin
      if (!in_list_q[fl.alloc_idx]) begin
        err_s = 1'b1;
      end else begin
        err_s = err_s;
      end
      in_list_d[fl.alloc_idx] = 1'b0;
    end else begin
      in_list_d = in_list_d;
    end

    // Entries renamed but not retired go back to the pool on recovery.
    if (fl.flush) begin
      for (int k = 0; k < FL_DEPTH; k++) begin
        if (k < int'(inflight_s)) begin
          rs_slot_s = FL_IDX_W'((int'(arch_head_d[FL_IDX_W-1:0]) + k) % FL_DEPTH);
          in_list_d[mem_q[rs_slot_s]] = 1'b1;
        end else begin
          rs_slot_s = rs_slot_s;
        end
      end
    end else begin
      in_list_d = in_list_d;
    end

    if (fl.commit_valid) begin
      if (full_s || in_list_q[fl.commit_old_phy]) begin
        err_s = 1'b1;
      end else begin
        err_s = err_s;
      end
      if (push_s) begin
        in_list_d[fl.commit_old_phy] = 1'b1;
      end else begin
        in_list_d = in_list_d;
      end
    end else begin
      err_s = err_s;
    end
  end

  // Membership vector and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_list_q <= {{FL_DEPTH{1'b1}}, {ARF_DEPTH{1'b0}}};
      fl_err_q  <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      fl_err_q  <= fl_err_q | err_s;
    end
  end

  // Report each integrity violation as it is detected.
  always_ff @(posedge clk) begin
    if (rst_n && err_s) begin
      $error("prf_free_list: integrity violation (double free, overflow or double alloc)");
    end
  end

  assign fl.fl_err = fl_err_q;
`else
  assign fl.fl_err = 1'b0;
`endif

endmodule
